aes_subbytes_pipe: RTL

Pipelined, multi-lane AES byte-substitution unit: applies the FIPS-197 forward S-box (encrypt) or inverse S-box (decrypt) to LANES bytes per beat. It sits between the round-state register and ShiftRows/MixColumns in the round datapath and carries a valid/ready handshake so the round controller can stall it. It is the parametrised successor to the single-byte combinational S-box: it is multi-lane, bidirectional and registered, with backpressure.

---
 rtl/aes_subbytes_pipe.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/aes_subbytes_pipe.sv
`default_nettype none
// ============================================================================
// aes_subbytes_pipe : two-stage, multi-lane AES forward/inverse S-box with
//                     valid/ready backpressure and an output handshake counter.
// Revision: 1.0
// ============================================================================
module aes_subbytes_pipe #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               out_inv,
  output logic [15:0]        out_count
);

  // Byte k of each table lives at bits [(255-k)*8 +: 8], i.e. index {~k, 3'b000}.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x, input logic inv);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return inv ? SBOX_INV[idx +: 8] : SBOX_FWD[idx +: 8];
  endfunction

  logic               v1_q, v1_d;
  logic               inv1_q, inv1_d;
  logic [8*LANES-1:0] data1_q, data1_d;
  logic               v2_q, v2_d;
  logic               inv2_q, inv2_d;
  logic [8*LANES-1:0] data2_q, data2_d;
  logic [15:0]        count_q, count_d;
  logic [8*LANES-1:0] lookup;
  logic               en1, en2;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lookup[8*i +: 8] = sbox_lookup(data1_q[8*i +: 8], inv1_q);
  end

  always_comb begin
    en2      = !v2_q | out_ready;
    en1      = !v1_q | en2;
    // rst_n gates in_ready so nothing is offered as accepted while held in reset.
    in_ready = en1 & !clr & rst_n;

    v1_d    = v1_q;
    inv1_d  = inv1_q;
    data1_d = data1_q;
    v2_d    = v2_q;
    inv2_d  = inv2_q;
    data2_d = data2_q;
    count_d = count_q;

    if (clr) begin
      v1_d = 1'b0;
    end else if (en1) begin
      v1_d = in_valid;
      if (in_valid) begin
        inv1_d  = in_inv;
        data1_d = in_data;
      end
    end

    if (clr) begin
      v2_d = 1'b0;
    end else if (en2) begin
      v2_d = v1_q;
      if (v1_q) begin
        inv2_d  = inv1_q;
        data2_d = lookup;
      end
    end

    if (clr) begin
      count_d = 16'd0;
    end else if (v2_q & out_ready) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      inv1_q  <= 1'b0;
      data1_q <= '0;
      v2_q    <= 1'b0;
      inv2_q  <= 1'b0;
      data2_q <= '0;
      count_q <= 16'd0;
    end else begin
      v1_q    <= v1_d;
      inv1_q  <= inv1_d;
      data1_q <= data1_d;
      v2_q    <= v2_d;
      inv2_q  <= inv2_d;
      data2_q <= data2_d;
      count_q <= count_d;
    end
  end

  assign out_valid = v2_q;
  assign out_inv   = inv2_q;
  assign out_data  = data2_q;
  assign out_count = count_q;

endmodule
`default_nettype wire
